// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared encodings for the instruction loader and the control decoder
//
// Contents:
//   loader_state_t     loader FSM encoding (IDLE, RECV, WRITE, DONE)
//   DEFAULT_HALT_WORD  terminator word that ends a load
//   OP_*               opcode-class constants that the decoder also uses
//   opcode_is_legal()  true for opcodes the decoder implements
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // Exact-match opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // Class prefixes on opcode[5:3]; the low three bits select the member
  localparam logic [2:0] OP_CLS_ALUI  = 3'b001;
  localparam logic [2:0] OP_CLS_LOAD  = 3'b100;
  localparam logic [2:0] OP_CLS_STORE = 3'b101;

  function automatic logic opcode_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) ||
           (op == OP_BEQ) || (op == OP_BNE) ||
           (op[5:3] == OP_CLS_ALUI) || (op[5:3] == OP_CLS_LOAD) ||
           (op[5:3] == OP_CLS_STORE);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - byte stream in and instruction-memory write bus out
//
// Signals:
//   rx_data[7:0], rx_valid, rx_ready   byte handshake from the receiver
//   imem_we, imem_addr, imem_wdata     one-cycle word write into instruction memory
// Modports:
//   master  environment side: drives the byte stream, observes the memory bus
//   slave   loader side: consumes the byte stream, drives the memory bus
interface instruction_loader_if #(
  parameter int ADDR_W = 8
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/opcode_legal_check.sv
// rtl/opcode_legal_check.sv - combinational legality test of a 6-bit opcode
//
// Ports:
//   opcode[5:0]  in   instruction bits [31:26]
//   legal        out  1 when the decoder supports the opcode
module opcode_legal_check
  import loader_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       legal
);

  assign legal = opcode_is_legal(opcode);

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - assembles received bytes into words and writes instruction memory
//
// Optional feature macro: LOADER_OPCODE_CHECK_EN (flags unsupported opcodes via error).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle pulse, begins a load at word address 0 (ignored while busy)
//   bus         slave modport: rx_data/rx_valid/rx_ready byte stream,
//               imem_we/imem_addr/imem_wdata memory write bus
//   busy        out  high in RECV/WRITE, stalls the pipeline
//   done        out  sticky, load finished (HALT written or memory full)
//   error       out  sticky, memory overflow or unsupported opcode
//   word_count  out  words written in the current load, HALT included
module instruction_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  instruction_loader_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W:0]      word_count
);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [1:0]        byte_cnt;
  logic [31:0]       shift;
  logic [ADDR_W-1:0] addr;

  logic        start_ok;
  logic        byte_take;
  logic        last_byte;
  logic [31:0] word_nxt;
  logic        word_is_halt;
  logic        addr_full;
  logic        op_bad;

  assign start_ok     = start && ((state == IDLE) || (state == DONE));
  assign byte_take    = (state == RECV) && bus.rx_valid;
  assign last_byte    = byte_take && (byte_cnt == 2'd3);
  assign word_nxt     = {shift[23:0], bus.rx_data};
  // imem_wdata holds the word being written for the whole WRITE cycle
  assign word_is_halt = (bus.imem_wdata == HALT_WORD);
  assign addr_full    = (addr == {ADDR_W{1'b1}});

`ifdef LOADER_OPCODE_CHECK_EN
  logic op_legal;

  opcode_legal_check u_opcode_legal_check (
    .opcode (bus.imem_wdata[31:26]),
    .legal  (op_legal)
  );

  // The terminator is never an instruction, so it is exempt from the check
  assign op_bad = !word_is_halt && !op_legal;
`else
  assign op_bad = 1'b0;
`endif

  assign bus.rx_ready = (state == RECV);
  assign bus.imem_we  = (state == WRITE);
  assign busy         = (state == RECV) || (state == WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RECV;
      RECV:    if (last_byte) state_nxt = WRITE;
      WRITE:   state_nxt = (word_is_halt || addr_full) ? DONE : RECV;
      DONE:    if (start) state_nxt = RECV;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt       <= 2'd0;
      shift          <= 32'd0;
      addr           <= '0;
      word_count     <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
    end else begin
      if (start_ok) begin
        byte_cnt   <= 2'd0;
        shift      <= 32'd0;
        addr       <= '0;
        word_count <= '0;
        done       <= 1'b0;
        error      <= 1'b0;
      end

      if (byte_take) begin
        shift    <= word_nxt;
        byte_cnt <= byte_cnt + 2'd1;
        // Capture the write address and data at the 4th byte so both are
        // stable flops for the single WRITE cycle that follows.
        if (byte_cnt == 2'd3) begin
          bus.imem_addr  <= addr;
          bus.imem_wdata <= word_nxt;
        end
      end

      if (state == WRITE) begin
        word_count <= word_count + 1'b1;
        if (word_is_halt) begin
          done <= 1'b1;
        end else if (addr_full) begin
          done  <= 1'b1;
          error <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
        if (op_bad) begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction stream that the ID-stage control decoder consumes.
- Accepts bytes from the debug/UART receiver over a valid/ready handshake and assembles them MSB-first into 32-bit instruction words.
- Writes each word sequentially into instruction memory from word address 0 and stops on a HALT word.
- Holds the pipeline stalled via `busy` while loading.

Parameters:
- ADDR_W, 8, instruction memory word-address width (depth = 2^ADDR_W words).
- HALT_WORD, 32'hFFFF_FFFF, terminator word; it is written to memory, then loading ends.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load at address 0.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  assembled instruction word.
- busy  out  1  high in RECV/WRITE; the pipeline stalls (control unit enable low) while set.
- done  out  1  sticky; load finished (HALT written or overflow).
- error  out  1  sticky; overflow or illegal opcode.
- word_count  out  ADDR_W+1  words written in the current load, HALT included.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - All outputs 0, including rx_ready, imem_we, imem_addr, imem_wdata, busy, done, error, word_count.
  - Byte counter and shift register cleared.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: `start` -> RECV; clears addr, word_count, byte counter, done, error.
- DONE:
  - `start` -> RECV with the same clears.
  - Otherwise holds; done=1.
- Byte handshake:
  - rx_ready=1 only in RECV.
  - A byte is accepted on a clock edge with rx_valid&&rx_ready.
  - Each accepted byte does shift = {shift[23:0], rx_data}; byte counter increments 0..3.
- 4th byte accepted at edge N:
  - Byte counter wraps to 0 and state -> WRITE.
  - During cycle N+1: imem_we=1, imem_wdata=assembled word, imem_addr=current addr, rx_ready=0.
- Exit from WRITE at edge N+2:
  - word_count increments.
  - If word==HALT_WORD -> DONE, done=1.
  - Else if addr==2^ADDR_W-1 (memory full, non-HALT written) -> DONE, done=1, error=1.
  - Else addr+1 and back to RECV.
- Output timing: imem_we is high for exactly one cycle per word. imem_addr/imem_wdata are registered and stable during that cycle.
- Ignored inputs:
  - `start` is ignored while busy (RECV/WRITE).
  - rx_valid outside RECV is ignored; the byte is not consumed.
- HALT on the last address: HALT written at addr 2^ADDR_W-1 ends normally, error=0.
- Partial word: bytes remaining at byte counter 1..3 with no more input keep the loader in RECV indefinitely. No timeout.
- Reset mid-load: immediate return to IDLE. Memory contents already written are not cleared.

Optional Feature:
- LOADER_OPCODE_CHECK_EN
- Defined: every non-HALT word's opcode [31:26] is checked against the decoder-supported set: 000000, 000010, 000011, 000100, 000101, 001xxx, 100xxx, 101xxx.
- A miss is handled as follows:
  - The word is still written.
  - error sets (sticky).
  - Loading continues.
- Undefined: no check. error is set only by overflow.

Decomposition:
- Shared package/header `loader_pkg`:
  - State encodings (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3).
  - Default HALT_WORD.
  - Opcode-class constants (OP_RTYPE=6'b000000, OP_J, OP_JAL, OP_BEQ, OP_BNE, class prefixes 3'b001/100/101). The control decoder reuses these constants.
- One sub-module is natural: `opcode_legal_check` (combinational, 6-bit opcode -> legal), instantiated only under LOADER_OPCODE_CHECK_EN.

Test Plan:
- Normal load: start, then bytes 20 08 00 05 | FF FF FF FF (rx_valid held high) -> imem_we at addr 0 data 32'h2008_0005; then addr 1 data FFFF_FFFF; done=1, error=0, word_count=2, busy=0.
- Handshake gaps: same stream with rx_valid toggling every other cycle -> identical writes; each imem_we exactly 1 cycle after the 4th accepted byte; rx_ready=0 during WRITE.
- Overflow with ADDR_W=2: start, then 4 non-HALT words -> 4 writes at addr 0..3; done=1, error=1, word_count=4; a 5th word's bytes are not consumed.
- Reset mid-word: start, 2 bytes, assert reset -> all outputs 0, state IDLE. A new start plus 00 00 00 00 FF FF FF FF writes 0 at addr 0 and HALT at addr 1.
- Start while busy: a pulse in RECV is ignored (addr unchanged). A start in DONE restarts at addr 0 and clears done/error.
- With LOADER_OPCODE_CHECK_EN: word 32'hFC00_0000 (opcode 111111) then HALT -> both written, error=1, done=1. Without the macro: error=0.
